uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 23 ++
 rtl/baud_tick_gen.sv | 40 ++++
 rtl/uart_receiver.sv | 152 +++++++++++++++
 tb/tb_uart_receiver.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state type and baud divisor helper
package uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int CLK_FREQ_DEF       = 100_000_000;
  localparam int BAUD_DEF           = 9600;
  localparam int OVERSAMPLE_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int rate;
    rate = baud * oversample;
    return (clk_freq + rate / 2) / rate;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running oversample tick generator
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Count 0..DIV-1 and wrap, flagging the wrap as a one-clock tick.
  always_comb begin
    tick_d = (cnt_q == LAST);
    cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
  end

  // Divider state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling 8N1 UART receiver with framing error detection
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic tick;

  baud_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  logic sync1_q, sync2_q, prev_q;
  logic fall;

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  // Two-flop synchronizer plus edge-history flop; preset high so reset looks like an idle line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall = prev_q & ~sync2_q;

  // Frame FSM: next state, counters, shift register and one-clock result pulses.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            // A start bit that is high again at mid-bit was only a glitch.
            state_d    = sync2_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {sync2_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            // Leave at stop-bit mid-point so a following start edge is not missed.
            state_d    = IDLE;
            tick_cnt_d = '0;
            if (sync2_q) begin
              rx_data_d = shift_q;
              done_d    = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= 8'h00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_done = done_q;
  assign rx_err  = err_q;
  assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

  // Scaled clocking: 10-unit clock, DIV = 4 clks/tick, 64 clks (640 units) per bit.
  localparam int CLK_HALF = 5;
  localparam int BIT      = 640;
  localparam int BIT_FAST = 627;
  localparam int BIT_SLOW = 653;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;

  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         both_cnt = 0;
  logic [7:0] got_q[$];
  longint     t_start  = 0;
  longint     t_done   = 0;

  uart_receiver #(
    .CLK_FREQ  (6_144_000),
    .BAUD      (96_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .rx_err (rx_err),
    .rx_busy(rx_busy)
  );

  always #CLK_HALF clk = ~clk;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt <= done_cnt + 1;
      got_q.push_back(rx_data);
      t_done <= $time;
    end
    if (rx_err) err_cnt <= err_cnt + 1;
    if (rx_done && rx_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int bit_ns, input logic stop_bit,
                            input logic release_line);
    rx = 1'b0;
    t_start = $time;
    #(bit_ns);
    for (int k = 0; k < 8; k++) begin
      rx = d[k];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
    if (release_line) rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    int         bit_ns;
    logic       stop_bit;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] b2b[3];
  int         d0, e0;
  longint     act;

  initial begin
    vecs[0] = '{8'h55, BIT,      1'b1, 1, 0, 8'h55};
    vecs[1] = '{8'h81, BIT_FAST, 1'b1, 1, 0, 8'h81};
    vecs[2] = '{8'h81, BIT_SLOW, 1'b1, 1, 0, 8'h81};
    vecs[3] = '{8'h3C, BIT,      1'b0, 0, 1, 8'h81};
    vecs[4] = '{8'h00, BIT,      1'b1, 1, 0, 8'h00};
    vecs[5] = '{8'hFF, BIT,      1'b1, 1, 0, 8'hFF};
    b2b[0] = 8'hA3;
    b2b[1] = 8'h00;
    b2b[2] = 8'hFF;

    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset rx_data", rx_data, 0);
    check("reset rx_done", rx_done, 0);
    check("reset rx_err", rx_err, 0);
    check("reset rx_busy", rx_busy, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].bit_ns, vecs[i].stop_bit, 1'b1);
      #(2 * BIT);
      @(negedge clk);
      check($sformatf("vec%0d done_pulses", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("vec%0d err_pulses", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_data);
      if (i == 0) check_range("latency", t_done - t_start, 6060, 6145);
    end

    // Back-to-back frames with no idle gap.
    d0 = done_cnt;
    for (int k = 0; k < 3; k++) send_frame(b2b[k], BIT, 1'b1, 1'b1);
    #(2 * BIT);
    @(negedge clk);
    check("b2b done_pulses", done_cnt - d0, 3);
    for (int k = 0; k < 3; k++) begin
      act = (got_q.size() > d0 + k) ? longint'(got_q[d0 + k]) : -1;
      check($sformatf("b2b byte%0d", k), act, b2b[k]);
    end

    // Short low glitch on an idle line.
    d0 = done_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    #30;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("glitch busy_rises", rx_busy, 1);
    repeat (31) @(negedge clk);
    check("glitch busy_clears", rx_busy, 0);
    #(2 * BIT);
    @(negedge clk);
    check("glitch done_pulses", done_cnt - d0, 0);
    check("glitch err_pulses", err_cnt - e0, 0);

    // Stop bit low, then line stuck low for 20 bit times.
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(8'h3C, BIT, 1'b0, 1'b0);
    #(20 * BIT);
    @(negedge clk);
    check("stuck err_pulses", err_cnt - e0, 1);
    check("stuck done_pulses", done_cnt - d0, 0);
    check("stuck rx_data", rx_data, 8'hFF);
    check("stuck busy", rx_busy, 0);
    rx = 1'b1;
    #(2 * BIT);
    @(negedge clk);
    check("stuck release err_pulses", err_cnt - e0, 1);
    check("stuck release done_pulses", done_cnt - d0, 0);

    // Reset pulse during bit 4 of 0x96; sender abandons the frame.
    d0 = done_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    #(BIT);
    for (int k = 0; k < 4; k++) begin
      rx = k[0] ? 1'b1 : 1'b0;
      if (k == 3) rx = 1'b0;
      if (k == 2) rx = 1'b1;
      #(BIT);
    end
    rx = 1'b1;
    #(BIT / 2);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #2;
    check("abort busy_in_reset", rx_busy, 0);
    check("abort rx_data_in_reset", rx_data, 0);
    #8;
    reset = 1'b0;
    #(12 * BIT);
    @(negedge clk);
    check("abort done_pulses", done_cnt - d0, 0);
    check("abort err_pulses", err_cnt - e0, 0);
    send_frame(8'h12, BIT, 1'b1, 1'b1);
    #(2 * BIT);
    @(negedge clk);
    check("after_abort done_pulses", done_cnt - d0, 1);
    check("after_abort rx_data", rx_data, 8'h12);
    check("after_abort err_pulses", err_cnt - e0, 0);

    check("done_err_overlap", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
